wasm_instr_fetch_decode: RTL



---
 rtl/wasm_instr_fetch_decode.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/wasm_instr_fetch_decode.sv
// wasm_instr_fetch_decode: decodes one WASM instruction per cycle from the
// 11-byte read window and steers the instruction memory controller's pointer.
// Optional macro FETCH_LEB_CHECK_EN: when defined, malformed LEB128 fields
// (no terminator, or non-canonical unused bits in a 32-bit field's 5th byte)
// raise out_illegal; when undefined only unknown opcodes raise it.

`ifndef INSTR_LOG2_BRAM_DEPTH
`define INSTR_LOG2_BRAM_DEPTH 16
`endif

module wasm_instr_fetch_decode #(
    parameter int ADDR_WIDTH = `INSTR_LOG2_BRAM_DEPTH,
    parameter int WIN_BYTES  = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic                    halt,
    input  logic                    redirect_vld,
    input  logic [ADDR_WIDTH-1:0]   redirect_addr,
    input  logic [WIN_BYTES*8-1:0]  rd_data,
    input  logic [ADDR_WIDTH-1:0]   read_pointer,
    output logic                    shift_vld,
    output logic [7:0]              read_pointer_shift_minusone,
    output logic                    jump_en,
    output logic [ADDR_WIDTH-1:0]   jump_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_opcode,
    output logic [63:0]             out_imm0,
    output logic [31:0]             out_imm1,
    output logic [3:0]              out_len,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic                    out_illegal
);

    generate
        if (WIN_BYTES != 11) begin : g_win_check
            $error("wasm_instr_fetch_decode: WIN_BYTES must be 11");
        end
    endgenerate

`ifdef FETCH_LEB_CHECK_EN
    localparam bit LEB_CHECK = 1'b1;
`else
    localparam bit LEB_CHECK = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // LEB length: index of first byte with bit7 clear, plus one, capped at max_bytes.
    function automatic logic [3:0] leb_len(input logic [79:0] b, input logic [3:0] max_bytes);
        logic [3:0] n;
        logic       found;
        n     = max_bytes;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!found && i < int'(max_bytes) && !b[8*i+7]) begin
                n     = 4'(i + 1);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Concatenated 7-bit payloads of the first len bytes, zero-extended.
    function automatic logic [63:0] leb_val(input logic [79:0] b, input logic [3:0] len);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 7; j++)
                if (i < int'(len) && 7*i+j < 64) v[7*i+j] = b[8*i+j];
        return v;
    endfunction

    // Payload sign-extended from the top payload bit of the last byte.
    function automatic logic [63:0] leb_sext(input logic [79:0] b, input logic [3:0] len);
        logic [63:0] v;
        logic        sign;
        v    = leb_val(b, len);
        sign = 1'b0;
        for (int i = 0; i < 10; i++)
            if (i == int'(len) - 1) sign = b[8*i+6];
        for (int k = 0; k < 64; k++)
            if (k >= 7*int'(len)) v[k] = sign;
        return v;
    endfunction

    // Malformed field: no terminator, or a 5-byte 32-bit field whose spare bits are not canonical.
    function automatic logic leb_bad(input logic [79:0] b, input logic [3:0] max_bytes, input logic sgn);
        logic       term;
        logic [6:0] fifth;
        logic       bad;
        term = 1'b0;
        for (int i = 0; i < 10; i++)
            if (i < int'(max_bytes) && !b[8*i+7]) term = 1'b1;
        fifth = b[38:32];
        bad   = !term;
        if (term && max_bytes == 4'd5 && leb_len(b, max_bytes) == 4'd5) begin
            if (sgn) bad = !(fifth[6:3] == 4'h0 || fifth[6:3] == 4'hF);
            else     bad = |fifth[6:4];
        end
        return bad;
    endfunction

    logic [1:0]  state, next_state;
    logic [7:0]  op;
    logic [79:0] imm_bytes;
    logic [3:0]  d_len;
    logic [63:0] d_imm0;
    logic [31:0] d_imm1;
    logic        d_illegal;
    logic        issue;
    logic        flush;

    assign op        = rd_data[7:0];
    assign imm_bytes = rd_data[87:8];

    // Opcode decode: length, immediates and illegal flag for the window's first instruction.
    always_comb begin
        logic [3:0]  len_a;
        logic [3:0]  len_b;
        logic [79:0] bytes_b;
        logic [63:0] sx;
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        d_len     = 4'd1;
        d_imm0    = '0;
        d_imm1    = '0;
        d_illegal = 1'b0;
        len_a     = leb_len(imm_bytes, 4'd5);
        bytes_b   = imm_bytes >> {len_a, 3'b000};
        len_b     = leb_len(bytes_b, 4'd5);
        sx        = '0;
        if (op inside {[8'h02:8'h04]}) begin
            d_len  = 4'd2;
            d_imm0 = {56'b0, imm_bytes[7:0]};
        end else if (op inside {8'h0C, 8'h0D, 8'h10, [8'h20:8'h24]}) begin
            d_len     = 4'd1 + len_a;
            d_imm0    = {32'b0, 32'(leb_val(imm_bytes, len_a))};
            d_illegal = LEB_CHECK & leb_bad(imm_bytes, 4'd5, 1'b0);
        end else if (op == 8'h41) begin
            sx        = leb_sext(imm_bytes, len_a);
            d_len     = 4'd1 + len_a;
            d_imm0    = {{32{sx[31]}}, sx[31:0]};
            d_illegal = LEB_CHECK & leb_bad(imm_bytes, 4'd5, 1'b1);
        end else if (op == 8'h42) begin
            d_len     = 4'd1 + leb_len(imm_bytes, 4'd10);
            d_imm0    = leb_sext(imm_bytes, leb_len(imm_bytes, 4'd10));
            d_illegal = LEB_CHECK & leb_bad(imm_bytes, 4'd10, 1'b1);
        end else if (op == 8'h43) begin
            d_len  = 4'd5;
            d_imm0 = {32'b0, imm_bytes[31:0]};
        end else if (op == 8'h44) begin
            d_len  = 4'd9;
            d_imm0 = imm_bytes[63:0];
        end else if (op inside {[8'h28:8'h3E]}) begin
            d_len     = 4'd1 + len_a + len_b;
            d_imm0    = {32'b0, 32'(leb_val(imm_bytes, len_a))};
            d_imm1    = 32'(leb_val(bytes_b, len_b));
            d_illegal = LEB_CHECK & (leb_bad(imm_bytes, 4'd5, 1'b0) | leb_bad(bytes_b, 4'd5, 1'b0));
        end else if (op == 8'h3F || op == 8'h40) begin
            d_len = 4'd2;
        end else if (op inside {8'h00, 8'h01, 8'h0B, 8'h0F, 8'h1A, 8'h1B, [8'h45:8'hC4]}) begin
            d_len = 4'd1;
        end else begin
            d_illegal = 1'b1;
        end
    end

    // Control: redirect beats everything; start only from IDLE/HALTED; issue only in RUN.
    always_comb begin
        next_state                  = state;
        shift_vld                   = 1'b0;
        jump_en                     = 1'b0;
        jump_addr                   = '0;
        read_pointer_shift_minusone = '0;
        issue                       = 1'b0;
        flush                       = 1'b0;
        if (redirect_vld && state != S_IDLE) begin
            shift_vld  = 1'b1;
            jump_en    = 1'b1;
            jump_addr  = redirect_addr;
            flush      = 1'b1;
            next_state = S_PRIME;
        end else if (start && (state == S_IDLE || state == S_HALTED)) begin
            shift_vld  = 1'b1;
            jump_en    = 1'b1;
            jump_addr  = start_addr;
            flush      = 1'b1;
            next_state = S_PRIME;
        end else if (state == S_PRIME) begin
            next_state = S_RUN;
        end else if (state == S_RUN && (!out_valid || out_ready) && !halt) begin
            issue                       = 1'b1;
            shift_vld                   = 1'b1;
            read_pointer_shift_minusone = {4'b0, d_len - 4'd1};
            next_state                  = d_illegal ? S_HALTED : S_RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Output register: load on issue, drop on flush, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_imm0    <= '0;
            out_imm1    <= '0;
            out_len     <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_opcode  <= op;
            out_imm0    <= d_imm0;
            out_imm1    <= d_imm1;
            out_len     <= d_len;
            out_pc      <= read_pointer;
            out_illegal <= d_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
